// File: rtl/otter_mem_responder.sv
// otter_mem_responder: main-memory slave for OTTER cache line refill/writeback.
// Takes one line request at a time. A read returns the line as a word-serial
// burst after a fixed latency. A write collects the line word by word and then
// pulses WR_DONE after the same latency.
// Optional build macro MEMRESP_CRITICAL_WORD_FIRST_EN: read bursts start at the
// requested word and wrap within the line. Without it, bursts start at word 0.
module otter_mem_responder #(
    parameter int WORDS_PER_LINE = 8,
    parameter int LATENCY        = 10,
    parameter int DEPTH_WORDS    = 16384
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic        WDATA_VALID,
    input  logic [31:0] WDATA,
    output logic        WDATA_READY,
    output logic        RDATA_VALID,
    output logic [31:0] RDATA,
    output logic        RDATA_LAST,
    output logic        WR_DONE
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int TAG_W = IDX_W - OFF_W;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_BURST, WR_COLLECT, WR_WAIT, WR_RESP
    } state_t;

    state_t            state, state_next;
    logic [TAG_W-1:0]  tag_q;       // line index within the array
    logic [OFF_W-1:0]  rd_ptr;      // word offset of the beat being fetched/shown
    logic [OFF_W-1:0]  word_cnt;    // beats sent or words collected so far
    logic [CNT_W-1:0]  lat_cnt;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept, wr_fire;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  start_off, fetch_off;
    logic              unused_addr;

    assign accept  = REQ_VALID && (state == IDLE);
    assign wr_fire = WDATA_VALID && (state == WR_COLLECT);
    assign req_tag = REQ_ADDR[IDX_W+1:OFF_W+2];

`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
    assign start_off   = REQ_ADDR[OFF_W+1:2];
    assign unused_addr = ^{REQ_ADDR[31:IDX_W+2], REQ_ADDR[1:0]};
`else
    assign start_off   = '0;
    assign unused_addr = ^{REQ_ADDR[31:IDX_W+2], REQ_ADDR[OFF_W+1:0]};
`endif

    // The RAM read runs one cycle ahead of the visible beat: while waiting,
    // fetch the first word; during the burst, fetch the next one.
    assign fetch_off = (state == RD_BURST) ? rd_ptr + 1'b1 : rd_ptr;

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (accept) state_next = REQ_WE ? WR_COLLECT : RD_WAIT;
            RD_WAIT:    if (lat_cnt == '0) state_next = RD_BURST;
            RD_BURST:   if (word_cnt == LAST_WORD) state_next = IDLE;
            WR_COLLECT: if (wr_fire && word_cnt == LAST_WORD) state_next = WR_WAIT;
            WR_WAIT:    if (lat_cnt == '0) state_next = WR_RESP;
            WR_RESP:    state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; data is zeroed outside the burst.
    always_comb begin
        REQ_READY   = (state == IDLE);
        WDATA_READY = (state == WR_COLLECT);
        RDATA_VALID = (state == RD_BURST);
        RDATA       = (state == RD_BURST) ? rdata_q : 32'h0;
        RDATA_LAST  = (state == RD_BURST) && (word_cnt == LAST_WORD);
        WR_DONE     = (state == WR_RESP);
    end

    // Request latching, latency countdown and word counting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_q    <= '0;
            rd_ptr   <= '0;
            word_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    tag_q    <= req_tag;
                    rd_ptr   <= start_off;
                    word_cnt <= '0;
                    lat_cnt  <= LAT_LOAD;
                end
                RD_WAIT: if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                RD_BURST: begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    word_cnt <= word_cnt + 1'b1;
                end
                WR_COLLECT: if (wr_fire) begin
                    word_cnt <= word_cnt + 1'b1;
                    if (word_cnt == LAST_WORD) lat_cnt <= LAT_LOAD;
                end
                WR_WAIT: if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Array write port; contents survive reset, but a word arriving with RST is dropped.
    always_ff @(posedge CLK) begin
        if (!RST && wr_fire) mem[{tag_q, word_cnt}] <= WDATA;
    end

    // Registered array read feeding the burst.
    always_ff @(posedge CLK) begin
        rdata_q <= mem[{tag_q, fetch_off}];
    end
endmodule

// File: tb/tb_otter_mem_responder.sv
// Directed bench for otter_mem_responder (W=8, LATENCY=10, DEPTH=16384).
module tb_otter_mem_responder;
    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID, REQ_WE, WDATA_VALID;
    logic [31:0] REQ_ADDR, WDATA;
    logic        REQ_READY, WDATA_READY, RDATA_VALID, RDATA_LAST, WR_DONE;
    logic [31:0] RDATA;

    int total = 0;
    int bad   = 0;

    otter_mem_responder #(.WORDS_PER_LINE(8), .LATENCY(10), .DEPTH_WORDS(16384)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .WDATA_VALID(WDATA_VALID), .WDATA(WDATA), .WDATA_READY(WDATA_READY),
        .RDATA_VALID(RDATA_VALID), .RDATA(RDATA), .RDATA_LAST(RDATA_LAST),
        .WR_DONE(WR_DONE)
    );

    always #5 CLK = ~CLK;

    // Advance one edge and settle away from it.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write one line; data word i = dbase + i. gap inserts an idle cycle before each word.
    task automatic wr_line(input logic [31:0] addr, input logic [31:0] dbase, input bit gap);
        int n;
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = addr;
        tick;
        REQ_VALID = 1'b0; REQ_WE = 1'b0;
        chk("wr_ready_on", WDATA_READY, 1);
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                WDATA_VALID = 1'b0;
                tick;
            end
            WDATA_VALID = 1'b1; WDATA = dbase + i;
            tick;
        end
        WDATA_VALID = 1'b0;
        chk("wr_ready_off", WDATA_READY, 0);
        n = 0;
        while (!WR_DONE && n < 30) begin
            tick;
            n++;
        end
        chk("wr_done_lat", n, 10);
        tick;
        chk("wr_done_pulse", WR_DONE, 0);
        chk("wr_idle_ready", REQ_READY, 1);
    endtask

    // Read one line holding dbase+i at word i. rst_beat>=0 aborts the burst with RST on
    // that beat; poke raises REQ_VALID during beat 2 which must be ignored.
    task automatic rd_line(input logic [31:0] addr, input logic [31:0] dbase,
                           input int rst_beat, input bit poke);
        int n, start, extra;
`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
        start = int'(addr[4:2]);
`else
        start = 0;
`endif
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = addr;
        tick;
        REQ_VALID = 1'b0;
        n = 0;
        while (!RDATA_VALID && n < 30) begin
            tick;
            n++;
        end
        chk("rd_lat", n, 10);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_beat) begin
                RST = 1'b1;
                tick;
                RST = 1'b0;
                chk("rst_valid", RDATA_VALID, 0);
                chk("rst_last", RDATA_LAST, 0);
                chk("rst_ready", REQ_READY, 1);
                return;
            end
            chk("rd_valid", RDATA_VALID, 1);
            chk("rd_data", RDATA, dbase + ((start + i) % 8));
            chk("rd_last", RDATA_LAST, (i == 7) ? 1 : 0);
            REQ_VALID = (poke && i == 2) ? 1'b1 : 1'b0;
            tick;
        end
        REQ_VALID = 1'b0;
        chk("rd_end_valid", RDATA_VALID, 0);
        chk("rd_end_ready", REQ_READY, 1);
        if (poke) begin
            extra = 0;
            repeat (20) begin
                tick;
                if (RDATA_VALID) extra++;
            end
            chk("no_extra_burst", extra, 0);
        end
    endtask

    initial begin
        RST = 1'b1; REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 32'h100;
        WDATA_VALID = 1'b0; WDATA = 32'h0;
        repeat (2) tick;
        chk("rst_req_ready", REQ_READY, 1);
        chk("rst_wdata_ready", WDATA_READY, 0);
        chk("rst_rdata_valid", RDATA_VALID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_rdata_last", RDATA_LAST, 0);
        chk("rst_wr_done", WR_DONE, 0);
        RST = 1'b0; REQ_VALID = 1'b0;
        tick;
        chk("post_rst_ready", REQ_READY, 1);

        wr_line(32'h100, 32'hA0, 1'b0);
        rd_line(32'h104, 32'hA0, -1, 1'b0);

        wr_line(32'h200, 32'hDEAD_0000, 1'b1);
        rd_line(32'h200, 32'hDEAD_0000, -1, 1'b0);

        rd_line(32'h10C, 32'hA0, -1, 1'b0);

        rd_line(32'h100, 32'hA0, 3, 1'b0);
        tick;
        chk("post_abort_quiet", RDATA_VALID, 0);
        rd_line(32'h100, 32'hA0, -1, 1'b0);

        wr_line(32'h10000, 32'hB0, 1'b0);
        rd_line(32'h0, 32'hB0, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/otter_mem_responder.md
Name: otter_mem_responder

Overview:
- Main-memory responder: the slave end of the cache-line refill/writeback channel driven by the OTTER instruction and data caches.
- Accepts one line request at a time. After a fixed latency it returns a read line as a word-serial burst, or collects a word-serial write line and then signals completion.
- Sits between the cache miss handlers (initiators, which hold PC_STALL / DCACHE_STALL while waiting) and the backing RAM array.

Parameters:
- WORDS_PER_LINE, 8, words per cache line; power of two, 2..16.
- LATENCY, 10, cycles from request acceptance to first read beat, or from last write word to WR_DONE; must be >= 1.
- DEPTH_WORDS, 16384, backing array size in 32-bit words; power of two.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  initiator presents a line request.
- REQ_READY  out  1  responder can accept a request; high only in IDLE.
- REQ_WE  in  1  1 = line write, 0 = line read; sampled at accept.
- REQ_ADDR  in  32  byte address; sampled at accept.
- WDATA_VALID  in  1  write word presented.
- WDATA  in  32  write word.
- WDATA_READY  out  1  responder accepts write words; high only in WR_COLLECT.
- RDATA_VALID  out  1  read beat valid; no backpressure.
- RDATA  out  32  read beat data.
- RDATA_LAST  out  1  marks final beat of a read burst.
- WR_DONE  out  1  one-cycle pulse when a write line is committed.

Behaviour:
- Reset values: REQ_READY=1, WDATA_READY=0, RDATA_VALID=0, RDATA=0, RDATA_LAST=0, WR_DONE=0; state IDLE.
- Reset does not clear the RAM array; words already written stay written.
- Accept = REQ_VALID & REQ_READY at a rising edge.
- At accept, latch line base = REQ_ADDR with low log2(WORDS_PER_LINE*4) bits cleared, latch REQ_WE, and latch requested word offset = REQ_ADDR[log2(W*4)-1:2].
- Array index = (byte address >> 2) mod DEPTH_WORDS. Higher address bits alias; no error is reported.
- Only one outstanding request. No new request is accepted until the current one returns to IDLE.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_COLLECT, WR_WAIT, WR_RESP.
- IDLE -> RD_WAIT on accept with REQ_WE=0, loading the latency counter with LATENCY-1.
- RD_WAIT: count down. At counter 0 go to RD_BURST.
- RD_WAIT timing: the first beat is visible exactly LATENCY edges after the accept edge.
- RD_BURST: RDATA_VALID=1 for exactly WORDS_PER_LINE consecutive cycles. Beat i carries word base+i, i = 0..W-1, in ascending order.
- RD_BURST end: RDATA_LAST=1 on beat W-1. Go to IDLE on the following edge, so REQ_READY=1 in the cycle after the last beat.
- IDLE -> WR_COLLECT on accept with REQ_WE=1.
- WR_COLLECT: WDATA_READY=1. Each WDATA_VALID & WDATA_READY edge writes WDATA to word base+k, then k++. Gaps in WDATA_VALID are allowed. After the W-th word, go to WR_WAIT.
- WR_WAIT: count LATENCY-1..0, then go to WR_RESP.
- WR_RESP: WR_DONE=1 for one cycle, then go to IDLE.
- Timing: WR_DONE rises LATENCY edges after the edge that accepted the last word.
- WDATA_VALID outside WR_COLLECT is ignored. REQ_VALID outside IDLE is ignored; the request is not queued.
- RST in any state: on the next edge, return to IDLE and drive reset output values. A burst or collect in progress is abandoned; no further beats and no WR_DONE.
- Read-after-write to the same line returns the newly written data. Writes are committed into the array before WR_DONE.

Optional Feature:
- Macro MEMRESP_CRITICAL_WORD_FIRST_EN.
- Defined: read bursts start at the latched requested word offset and wrap modulo WORDS_PER_LINE. Beat i carries word base + ((off+i) mod W). RDATA_LAST stays on the W-th beat. Writes are unaffected.
- Undefined: offset is ignored and beats always start at word 0.

Test Plan (W=8, LATENCY=10, DEPTH=16384):
- Reset: hold RST 2 cycles -> all outputs 0 except REQ_READY=1. REQ_VALID during RST is not accepted.
- Write 0x100 with 0xA0..0xA7 back-to-back, then read 0x104 -> WR_DONE pulses 10 edges after the 8th word; first RDATA_VALID exactly 10 edges after the read accept; data 0xA0..0xA7; RDATA_LAST only on 0xA7; REQ_READY=1 next cycle.
- Write 0x200 with WDATA_VALID toggling 1/0 -> 8 words stored in order; read 0x200 returns them exactly; WDATA_READY=0 after the 8th word.
- MEMRESP_CRITICAL_WORD_FIRST_EN defined, read 0x10C after the 0x100 write -> 0xA3,0xA4,0xA5,0xA6,0xA7,0xA0,0xA1,0xA2; LAST on 0xA2. Macro undefined -> 0xA0..0xA7.
- RST asserted during read beat 3 -> RDATA_VALID=0 on the next edge, no LAST, REQ_READY=1. A fresh read of 0x100 returns the full correct line.
- Aliasing: write 0x10000 with 0xB0..0xB7, read 0x0 -> 0xB0..0xB7. A REQ_VALID pulse during the burst is ignored, with no extra burst afterwards.
